tetris_blitter: RTL and testbench

TETRIS_BLITTER -- requirements
Module: tetris_blitter

---
 rtl/tetris_blitter_pkg.sv | 27 ++
 rtl/tetris_blitter.sv | 167 ++++++++++++++++
 tb/tb_tetris_blitter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_blitter_pkg.sv
// Shared definitions for the rectangle blitter: display limits, register map,
// control/status bit positions and the fill state machine encoding.
package tetris_blitter_pkg;

  localparam int DISP_H_RES = 800;
  localparam int DISP_V_RES = 600;

  localparam logic [2:0] REG_ORIGIN = 3'd0;
  localparam logic [2:0] REG_SIZE   = 3'd1;
  localparam logic [2:0] REG_COLOR  = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_CLR_DONE = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_CLIPPED = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_FINISH = 2'd2
  } blit_state_e;

endpackage

// File: rtl/tetris_blitter.sv
// Wishbone-controlled rectangle fill engine: streams one solid-colour rectangle
// into the frame RAM write port in raster order, dropping off-screen pixels.
module tetris_blitter
  import tetris_blitter_pkg::*;
#(
  parameter int H_RES = DISP_H_RES,
  parameter int V_RES = DISP_V_RES
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [7:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        pix_valid,
  output logic [9:0]  pix_row,
  output logic [9:0]  pix_col,
  output logic [11:0] pix_rgb,
  input  logic        pix_ready,
  output logic        done_irq
);

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);

  blit_state_e state_reg, state_next;

  logic [19:0] origin_reg;
  logic [19:0] size_reg;
  logic [11:0] color_reg;
  logic        done_reg;
  logic        clipped_reg;

  logic [9:0]  work_row_reg, work_col_reg;
  logic [9:0]  work_h_reg, work_w_reg;
  logic [11:0] work_rgb_reg;
  logic [9:0]  row_idx_reg, col_idx_reg;

  logic [2:0]  reg_sel;
  logic        wr_en, ctrl_wr, start_cmd, abort_cmd, start_go;
  logic [10:0] cur_row, cur_col;
  logic        clip_now, advance, last_pix, row_end;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{wb_adr_i[7:5], wb_adr_i[1:0], wb_dat_i[31:20]};

  assign reg_sel   = wb_adr_i[4:2];
  assign wr_en     = wb_ack_o && wb_cyc_i && wb_stb_i && wb_we_i;
  assign ctrl_wr   = wr_en && (reg_sel == REG_CTRL);
  // ABORT wins over START when both bits arrive in one write
  assign start_cmd = ctrl_wr && wb_dat_i[CTRL_START] && !wb_dat_i[CTRL_ABORT];
  assign abort_cmd = ctrl_wr && wb_dat_i[CTRL_ABORT];
  assign start_go  = (state_reg == ST_IDLE) && start_cmd;

  assign cur_row  = {1'b0, work_row_reg} + {1'b0, row_idx_reg};
  assign cur_col  = {1'b0, work_col_reg} + {1'b0, col_idx_reg};
  assign clip_now = (cur_col >= H_LIM) || (cur_row >= V_LIM);
  assign row_end  = (col_idx_reg == work_w_reg - 10'd1);
  assign last_pix = row_end && (row_idx_reg == work_h_reg - 10'd1);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_cmd) begin
          if (size_reg[19:10] == 10'd0 || size_reg[9:0] == 10'd0) state_next = ST_FINISH;
          else                                                      state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        if (abort_cmd)               state_next = ST_IDLE;
        else if (advance && last_pix) state_next = ST_FINISH;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_valid = (state_reg == ST_FILL) && !clip_now;
    pix_row   = cur_row[9:0];
    pix_col   = cur_col[9:0];
    pix_rgb   = work_rgb_reg;
    // off-screen pixels step through in a single cycle without a handshake
    advance   = (state_reg == ST_FILL) && (clip_now || pix_ready);
  end

  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      REG_ORIGIN: rd_data = {12'd0, origin_reg};
      REG_SIZE:   rd_data = {12'd0, size_reg};
      REG_COLOR:  rd_data = {20'd0, color_reg};
      REG_CTRL:   rd_data = {29'd0, clipped_reg, done_reg, state_reg != ST_IDLE};
      default:    rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= 32'd0;
      origin_reg <= 20'd0;
      size_reg   <= 20'd0;
      color_reg  <= 12'd0;
    end else begin
      wb_ack_o <= !wb_ack_o && wb_stb_i && wb_cyc_i;
      if (!wb_ack_o && wb_stb_i && wb_cyc_i) wb_dat_o <= rd_data;
      if (wr_en) begin
        case (reg_sel)
          REG_ORIGIN: origin_reg <= wb_dat_i[19:0];
          REG_SIZE:   size_reg   <= wb_dat_i[19:0];
          REG_COLOR:  color_reg  <= wb_dat_i[11:0];
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      work_row_reg <= 10'd0;
      work_col_reg <= 10'd0;
      work_h_reg   <= 10'd0;
      work_w_reg   <= 10'd0;
      work_rgb_reg <= 12'd0;
      row_idx_reg  <= 10'd0;
      col_idx_reg  <= 10'd0;
      done_reg     <= 1'b0;
      clipped_reg  <= 1'b0;
      done_irq     <= 1'b0;
    end else begin
      done_irq <= (state_reg == ST_FINISH);
      if (start_go) begin
        work_row_reg <= origin_reg[19:10];
        work_col_reg <= origin_reg[9:0];
        work_h_reg   <= size_reg[19:10];
        work_w_reg   <= size_reg[9:0];
        work_rgb_reg <= color_reg;
        row_idx_reg  <= 10'd0;
        col_idx_reg  <= 10'd0;
        clipped_reg  <= 1'b0;
      end else if (advance) begin
        if (clip_now) clipped_reg <= 1'b1;
        if (row_end) begin
          col_idx_reg <= 10'd0;
          row_idx_reg <= row_idx_reg + 10'd1;
        end else begin
          col_idx_reg <= col_idx_reg + 10'd1;
        end
      end
      if (state_reg == ST_FINISH)                      done_reg <= 1'b1;
      else if (start_go)                               done_reg <= 1'b0;
      else if (ctrl_wr && wb_dat_i[CTRL_CLR_DONE])     done_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tetris_blitter.sv
// Directed bench for tetris_blitter: register access, normal/stalled/clipped/
// empty fills, abort and asynchronous reset, against hand-computed pixels.
module tb_tetris_blitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [7:0]  wb_adr = 8'd0;
  logic [31:0] wb_dat = 32'd0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        pix_valid, pix_ready = 1'b0, done_irq;
  logic [9:0]  pix_row, pix_col;
  logic [11:0] pix_rgb;

  tetris_blitter dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb_cyc_i (wb_cyc),
    .wb_stb_i (wb_stb),
    .wb_we_i  (wb_we),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .pix_valid(pix_valid),
    .pix_row  (pix_row),
    .pix_col  (pix_col),
    .pix_rgb  (pix_rgb),
    .pix_ready(pix_ready),
    .done_irq (done_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  r;
    logic [9:0]  c;
    logic [11:0] rgb;
    int          cyc;
  } pix_t;

  int   n_tests = 0, n_fail = 0;
  int   cyc_cnt = 0;
  int   done_cnt = 0, done_cyc = 0, stable_err = 0;
  int   ack_cyc = 0;
  pix_t pq[$];

  logic        prev_hold = 1'b0;
  logic [9:0]  prev_row = '0, prev_col = '0;
  logic [11:0] prev_rgb = '0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (pix_valid && pix_ready) pq.push_back('{pix_row, pix_col, pix_rgb, cyc_cnt});
    if (done_irq) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc_cnt;
    end
    if (prev_hold && !(pix_valid && pix_row == prev_row && pix_col == prev_col && pix_rgb == prev_rgb))
      stable_err = stable_err + 1;
    prev_hold = pix_valid && !pix_ready;
    prev_row  = pix_row;
    prev_col  = pix_col;
    prev_rgb  = pix_rgb;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat);
    wb_adr = adr; wb_dat = dat; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    check("wr_ack", {31'd0, wb_ack_o}, 32'd1);
    ack_cyc = cyc_cnt;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] adr, output logic [31:0] dat);
    wb_adr = adr; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    check("rd_ack", {31'd0, wb_ack_o}, 32'd1);
    dat = wb_dat_o;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic wait_done(input int snap, input int max_cyc);
    for (int k = 0; k < max_cyc && done_cnt == snap; k++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  localparam logic [7:0] A_ORIGIN = 8'h00, A_SIZE = 8'h04, A_COLOR = 8'h08, A_CTRL = 8'h0C;

  function automatic logic [31:0] rc(input int r, input int c);
    return 32'((r << 10) | c);
  endfunction

  initial begin
    logic [31:0] rd;
    int base, dsnap, ssnap, last_cyc;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {29'd0, pix_valid, done_irq, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_read(A_CTRL, rd);   check("rst_status", rd, 32'd0);
    wb_read(A_ORIGIN, rd); check("rst_origin", rd, 32'd0);
    check("ack_single", {31'd0, wb_ack_o}, 32'd0);

    // register width masking and unused addresses
    wb_write(A_ORIGIN, 32'hFFFF_FFFF); wb_read(A_ORIGIN, rd); check("origin_mask", rd, 32'h000F_FFFF);
    wb_write(A_COLOR, 32'hFFFF_FFFF);  wb_read(A_COLOR, rd);  check("color_mask", rd, 32'h0000_0FFF);
    wb_write(8'h14, 32'h1234_5678);    wb_read(8'h14, rd);    check("addr5_zero", rd, 32'd0);

    // basic 2x3 fill at (2,3), ready always high
    pix_ready = 1'b1;
    wb_write(A_ORIGIN, rc(2, 3));
    wb_write(A_SIZE, rc(2, 3));
    wb_write(A_COLOR, 32'hF00);
    base = pq.size(); dsnap = done_cnt;
    wb_write(A_CTRL, 32'h1);
    wait_done(dsnap, 40);
    check("fill_count", pq.size() - base, 6);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++) begin
        check("fill_rc", {12'd0, pq[base + i*3 + j].r, pq[base + i*3 + j].c}, rc(2 + i, 3 + j));
        check("fill_rgb", {20'd0, pq[base + i*3 + j].rgb}, 32'hF00);
        check("fill_cyc", pq[base + i*3 + j].cyc, ack_cyc + 1 + i*3 + j);
      end
    check("fill_done_cnt", done_cnt - dsnap, 1);
    check("fill_done_cyc", done_cyc, ack_cyc + 8);
    wb_read(A_CTRL, rd); check("fill_status", rd, 32'h2);
    wb_write(A_CTRL, 32'h4);
    wb_read(A_CTRL, rd); check("clr_done", rd, 32'h0);

    // same fill with pix_ready toggling every cycle
    base = pq.size(); dsnap = done_cnt; ssnap = stable_err;
    wb_write(A_CTRL, 32'h1);
    for (int k = 0; k < 40; k++) begin
      pix_ready = ~pix_ready;
      @(posedge clk); #1;
    end
    pix_ready = 1'b1;
    check("tog_count", pq.size() - base, 6);
    for (int k = 0; k < 6 && k < pq.size() - base; k++)
      check("tog_rc", {12'd0, pq[base + k].r, pq[base + k].c}, rc(2 + k/3, 3 + k%3));
    check("tog_stable", stable_err - ssnap, 0);
    check("tog_done_cnt", done_cnt - dsnap, 1);
    last_cyc = (pq.size() > 0) ? pq[pq.size() - 1].cyc : 0;
    check("tog_done_cyc", done_cyc, last_cyc + 2);

    // bottom-right corner, 4x4 partly off-screen
    wb_write(A_ORIGIN, rc(598, 798));
    wb_write(A_SIZE, rc(4, 4));
    base = pq.size(); dsnap = done_cnt;
    wb_write(A_CTRL, 32'h1);
    wait_done(dsnap, 60);
    check("clip_count", pq.size() - base, 4);
    for (int k = 0; k < 4 && k < pq.size() - base; k++)
      check("clip_rc", {12'd0, pq[base + k].r, pq[base + k].c}, rc(598 + k/2, 798 + k%2));
    check("clip_done_cnt", done_cnt - dsnap, 1);
    wb_read(A_CTRL, rd); check("clip_status", rd, 32'h6);

    // zero width: straight to FINISH
    wb_write(A_SIZE, rc(3, 0));
    base = pq.size(); dsnap = done_cnt;
    wb_write(A_CTRL, 32'h1);
    wait_done(dsnap, 20);
    check("empty_count", pq.size() - base, 0);
    check("empty_done_cyc", done_cyc, ack_cyc + 2);
    wb_read(A_CTRL, rd); check("empty_status", rd, 32'h2);

    // 10x10 fill aborted after 5 accepted pixels
    pix_ready = 1'b0;
    wb_write(A_ORIGIN, rc(0, 0));
    wb_write(A_SIZE, rc(10, 10));
    base = pq.size(); dsnap = done_cnt;
    wb_write(A_CTRL, 32'h1);
    pix_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    pix_ready = 1'b0;
    wb_write(A_CTRL, 32'h2);
    check("abort_valid", {31'd0, pix_valid}, 32'd0);
    check("abort_count", pq.size() - base, 5);
    for (int k = 0; k < 5 && k < pq.size() - base; k++)
      check("abort_rc", {12'd0, pq[base + k].r, pq[base + k].c}, rc(0, k));
    wb_read(A_CTRL, rd); check("abort_status", rd, 32'h0);
    check("abort_no_irq", done_cnt - dsnap, 0);

    // restart; writes and START during the fill must not disturb it
    pix_ready = 1'b1;
    base = pq.size(); dsnap = done_cnt;
    wb_write(A_CTRL, 32'h1);
    wb_write(A_ORIGIN, rc(50, 50));
    wb_write(A_CTRL, 32'h1);
    wait_done(dsnap, 200);
    check("restart_count", pq.size() - base, 100);
    if (pq.size() > 0)
      check("restart_last", {12'd0, pq[pq.size() - 1].r, pq[pq.size() - 1].c}, rc(9, 9));
    check("restart_done_cnt", done_cnt - dsnap, 1);

    // asynchronous reset in the middle of a fill
    wb_write(A_ORIGIN, rc(5, 7));
    wb_write(A_COLOR, 32'hABC);
    dsnap = done_cnt;
    wb_write(A_CTRL, 32'h1);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_flags", {29'd0, pix_valid, done_irq, wb_ack_o}, 32'd0);
    check("arst_rc", {12'd0, pix_row, pix_col}, 32'd0);
    check("arst_rgb", {20'd0, pix_rgb}, 32'd0);
    check("arst_dat", wb_dat_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = pq.size();
    wb_read(A_CTRL, rd); check("arst_status", rd, 32'h0);
    repeat (20) begin @(posedge clk); #1; end
    check("arst_no_pix", pq.size() - base, 0);
    check("arst_no_irq", done_cnt - dsnap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
